lcd_write_controller: RTL

Sequences one 8-bit command or character write to the Spartan-3E 4-bit character LCD (SF_D[11:8], LCD_E, LCD_RS, LCD_RW) on behalf of the core's `LCD` instruction. Splits the byte into high then low nibble, generates the setup, enable-pulse, hold and inter-nibble/inter-byte delays in 50 MHz clock cycles, and reports completion over a busy/done handshake. This lets the instruction ROM drop most of its padding `NOP` delay instructions. It sits between the core's execute stage and the LCD pins.

---
 rtl/lcd_write_controller.sv | 325 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_write_controller.sv
// -----------------------------------------------------------------------------
// lcd_write_controller
//
// Purpose: writes one 8-bit command or character byte to the Spartan-3E
// 4-bit character LCD. The byte goes out high nibble first, then low nibble.
// The block times the setup, enable pulse, hold and gap delays in system
// clock cycles, so the instruction ROM does not need padding NOP delays.
//
// Optional feature macro: LCD_POWERON_INIT_EN
//   Defined   -> after Reset the block runs the LCD power-on nibble sequence
//                (0x3, 0x3, 0x3, 0x2 with their waits) before it enters IDLE.
//                oBusy stays high for the whole sequence.
//   Undefined -> the block enters IDLE straight from reset.
//
// Ports:
//   Clock      in   system clock (50 MHz), rising edge
//   Reset      in   synchronous, active-high
//   iStart     in   write request; sampled only while oBusy=0
//   iData[7:0] in   byte to write; latched on acceptance
//   iRS        in   0 = command, 1 = data; latched on acceptance
//   oLCD_Data  out  LCD nibble bus (SF_D[11:8])
//   oLCD_E     out  LCD enable
//   oLCD_RS    out  LCD register select
//   oLCD_RW    out  constant 0 (write only)
//   oBusy      out  transfer or init in progress
//   oDone      out  one-cycle pulse at the end of a byte transfer
// -----------------------------------------------------------------------------
module lcd_write_controller #(
  parameter int SETUP_CYC      = 2,
  parameter int PULSE_CYC      = 12,
  parameter int HOLD_CYC       = 1,
  parameter int NIBBLE_GAP_CYC = 50,
  parameter int BYTE_GAP_CYC   = 2000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic [7:0] iData,
  input  logic       iRS,
  output logic [3:0] oLCD_Data,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic       oBusy,
  output logic       oDone
);

  // The counter is wide enough for the 750000-cycle power-on wait.
  localparam int CNT_W = 21;

  // Every state loads N-1 on entry and leaves when the counter reaches 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] NGAP_LD  = CNT_W'(NIBBLE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] BGAP_LD  = CNT_W'(BYTE_GAP_CYC - 1);

  typedef enum logic [3:0] {
    IDLE,
    SETUP_H,
    PULSE_H,
    HOLD_H,
    GAP_N,
    SETUP_L,
    PULSE_L,
    HOLD_L,
    GAP_B
`ifdef LCD_POWERON_INIT_EN
    ,
    INIT_WAIT0,
    INIT_SETUP,
    INIT_PULSE,
    INIT_HOLD,
    INIT_WAIT
`endif
  } state_t;

`ifdef LCD_POWERON_INIT_EN
  localparam state_t           RST_STATE     = INIT_WAIT0;
  localparam logic             RST_BUSY      = 1'b1;
  localparam logic [CNT_W-1:0] RST_CNT       = 21'd749999;

  // Wait that follows init nibble number 'step' (the count is N-1).
  function automatic logic [CNT_W-1:0] init_wait_ld(input logic [1:0] step);
    case (step)
      2'd0:    init_wait_ld = 21'd204999;
      2'd1:    init_wait_ld = 21'd4999;
      2'd2:    init_wait_ld = 21'd1999;
      default: init_wait_ld = 21'd1999;
    endcase
  endfunction

  // Nibble value for init step: the last step switches the LCD to 4-bit mode.
  function automatic logic [3:0] init_nibble(input logic [1:0] step);
    case (step)
      2'd3:    init_nibble = 4'h2;
      default: init_nibble = 4'h3;
    endcase
  endfunction

  logic [1:0] step_r, step_s;
`else
  localparam state_t           RST_STATE     = IDLE;
  localparam logic             RST_BUSY      = 1'b0;
  localparam logic [CNT_W-1:0] RST_CNT       = 21'd0;
`endif

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       byte_r, byte_s;
  logic [3:0]       data_r, data_s;
  logic             e_r, e_s;
  logic             rs_r, rs_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             cnt_zero_s;

  assign cnt_zero_s = (cnt_r == 21'd0);

  // Next-state, counter and next-output decode; outputs are registered below.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r - 21'd1;
    byte_s  = byte_r;
    data_s  = data_r;
    e_s     = e_r;
    rs_s    = rs_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
`ifdef LCD_POWERON_INIT_EN
    step_s  = step_r;
`endif
    case (state_r)
      IDLE: begin
        if (iStart) begin
          state_s = SETUP_H;
          cnt_s   = SETUP_LD;
          byte_s  = iData;
          data_s  = iData[7:4];
          rs_s    = iRS;
          busy_s  = 1'b1;
        end else begin
          cnt_s   = 21'd0;
        end
      end
      SETUP_H: begin
        if (cnt_zero_s) begin
          state_s = PULSE_H;
          cnt_s   = PULSE_LD;
          e_s     = 1'b1;
        end else begin
          e_s     = 1'b0;
        end
      end
      PULSE_H: begin
        if (cnt_zero_s) begin
          state_s = HOLD_H;
          cnt_s   = HOLD_LD;
          e_s     = 1'b0;
        end else begin
          e_s     = 1'b1;
        end
      end
      HOLD_H: begin
        if (cnt_zero_s) begin
          state_s = GAP_N;
          cnt_s   = NGAP_LD;
        end else begin
          state_s = HOLD_H;
        end
      end
      GAP_N: begin
        // The low nibble goes onto the bus on the way out of the gap.
        if (cnt_zero_s) begin
          state_s = SETUP_L;
          cnt_s   = SETUP_LD;
          data_s  = byte_r[3:0];
        end else begin
          state_s = GAP_N;
        end
      end
      SETUP_L: begin
        if (cnt_zero_s) begin
          state_s = PULSE_L;
          cnt_s   = PULSE_LD;
          e_s     = 1'b1;
        end else begin
          e_s     = 1'b0;
        end
      end
      PULSE_L: begin
        if (cnt_zero_s) begin
          state_s = HOLD_L;
          cnt_s   = HOLD_LD;
          e_s     = 1'b0;
        end else begin
          e_s     = 1'b1;
        end
      end
      HOLD_L: begin
        if (cnt_zero_s) begin
          state_s = GAP_B;
          cnt_s   = BGAP_LD;
        end else begin
          state_s = HOLD_L;
        end
      end
      GAP_B: begin
        // Done and not-busy appear in the same cycle, so the next request
        // can be accepted in that cycle.
        if (cnt_zero_s) begin
          state_s = IDLE;
          cnt_s   = 21'd0;
          data_s  = 4'h0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s = GAP_B;
        end
      end
`ifdef LCD_POWERON_INIT_EN
      INIT_WAIT0: begin
        if (cnt_zero_s) begin
          state_s = INIT_SETUP;
          cnt_s   = SETUP_LD;
          step_s  = 2'd0;
          data_s  = init_nibble(2'd0);
          rs_s    = 1'b0;
        end else begin
          state_s = INIT_WAIT0;
        end
      end
      INIT_SETUP: begin
        if (cnt_zero_s) begin
          state_s = INIT_PULSE;
          cnt_s   = PULSE_LD;
          e_s     = 1'b1;
        end else begin
          e_s     = 1'b0;
        end
      end
      INIT_PULSE: begin
        if (cnt_zero_s) begin
          state_s = INIT_HOLD;
          cnt_s   = HOLD_LD;
          e_s     = 1'b0;
        end else begin
          e_s     = 1'b1;
        end
      end
      INIT_HOLD: begin
        if (cnt_zero_s) begin
          state_s = INIT_WAIT;
          cnt_s   = init_wait_ld(step_r);
        end else begin
          state_s = INIT_HOLD;
        end
      end
      INIT_WAIT: begin
        // The init sequence ends silently: no done pulse, just busy dropping.
        if (cnt_zero_s) begin
          if (step_r == 2'd3) begin
            state_s = IDLE;
            cnt_s   = 21'd0;
            data_s  = 4'h0;
            busy_s  = 1'b0;
          end else begin
            state_s = INIT_SETUP;
            cnt_s   = SETUP_LD;
            step_s  = step_r + 2'd1;
            data_s  = init_nibble(step_r + 2'd1);
          end
        end else begin
          state_s = INIT_WAIT;
        end
      end
`endif
      default: begin
        state_s = RST_STATE;
        cnt_s   = RST_CNT;
        data_s  = 4'h0;
        e_s     = 1'b0;
        rs_s    = 1'b0;
        busy_s  = RST_BUSY;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= RST_STATE;
      cnt_r   <= RST_CNT;
      byte_r  <= 8'h00;
      data_r  <= 4'h0;
      e_r     <= 1'b0;
      rs_r    <= 1'b0;
      busy_r  <= RST_BUSY;
      done_r  <= 1'b0;
`ifdef LCD_POWERON_INIT_EN
      step_r  <= 2'd0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      byte_r  <= byte_s;
      data_r  <= data_s;
      e_r     <= e_s;
      rs_r    <= rs_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
`ifdef LCD_POWERON_INIT_EN
      step_r  <= step_s;
`endif
    end
  end

  assign oLCD_Data = data_r;
  assign oLCD_E    = e_r;
  assign oLCD_RS   = rs_r;
  assign oLCD_RW   = 1'b0;
  assign oBusy     = busy_r;
  assign oDone     = done_r;

endmodule
